// File: rtl/msk_hpc2_feeder_pkg.sv
// msk_hpc2_feeder_pkg: shared masking parameters and HPC2 gadget constants.
package msk_hpc2_feeder_pkg;
    localparam int MSK_D = 2;
    localparam int HPC2_LAT = 2;
    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_ONE, FIFO_FULL} fifo_occ_e;
    function automatic int hpc2_nrnd(input int shares);
        return shares * (shares - 1) / 2;
    endfunction
endpackage

// File: rtl/msk_share_fifo2.sv
// msk_share_fifo2: two-entry FIFO of share words; push and pop may coincide at any occupancy.
module msk_share_fifo2 import msk_hpc2_feeder_pkg::*; #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    (* keep = "true" *) logic [W-1:0] mem_q [2];
    logic      rd_q, wr_q, do_push, do_pop;
    fifo_occ_e occ_q, occ_n;
    always_comb begin
        empty = occ_q == FIFO_EMPTY;
        full = occ_q == FIFO_FULL;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        occ_n = occ_q;
        if (do_push && !do_pop)
            occ_n = empty ? FIFO_ONE : FIFO_FULL;
        else if (do_pop && !do_push)
            occ_n = full ? FIFO_ONE : FIFO_EMPTY;
        dout = mem_q[rd_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= FIFO_EMPTY;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            occ_q <= occ_n;
            if (do_push) wr_q <= !wr_q;
            if (do_pop) rd_q <= !rd_q;
        end
    end
    // Storage is write-only on push; contents are never combined, only moved.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/msk_hpc2_feeder.sv
// msk_hpc2_feeder: buffers operand sharings and issues them to an HPC2 AND gadget
// together with fresh randomness, a-shares lagging b-shares by one cycle.
module msk_hpc2_feeder import msk_hpc2_feeder_pkg::*; #(
    parameter int d    = MSK_D,
    parameter int NRND = hpc2_nrnd(d)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [d-1:0]    a_shares,
    input  logic [d-1:0]    b_shares,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [NRND-1:0] rnd_in,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic [d-1:0]    ina,
    output logic [d-1:0]    inb,
    output logic [NRND-1:0] rnd,
    output logic            res_valid,
    output logic            busy
);
    if (d < 2) begin : g_bad_d
        $error("msk_hpc2_feeder needs at least two shares");
    end
    logic [2*d-1:0] head;
    logic           empty, full, issue, push;
    (* keep = "true" *) logic [d-1:0] ina_q;
    logic [HPC2_LAT-1:0] v_q;
    msk_share_fifo2 #(.W(2*d)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .din   ({a_shares, b_shares}),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );
    // Outputs are forced quiet while rst is high so nothing leaks during reset.
    always_comb begin
        issue = !rst && !empty && rnd_valid;
        push = op_valid && !full && !rst;
        op_ready = rst || !full;
        rnd_ready = issue;
        inb = issue ? head[d-1:0] : '0;
        rnd = issue ? rnd_in : '0;
        ina = rst ? '0 : ina_q;
        res_valid = !rst && v_q[HPC2_LAT-1];
        busy = !rst && (!empty || |v_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ina_q <= '0;
            v_q <= '0;
        end else begin
            ina_q <= issue ? head[2*d-1:d] : '0;
            v_q <= {v_q[HPC2_LAT-2:0], issue};
        end
    end
endmodule

// File: tb/tb_msk_hpc2_feeder.sv
// tb_msk_hpc2_feeder: scoreboard bench for the HPC2 feeder, d=2 directed plus d=3 through a gadget model.
module tb_msk_hpc2_feeder;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [1:0] a_sh, b_sh, ina, inb;
    logic [0:0] rnd_in, rnd;
    logic op_valid, op_ready, rnd_valid, rnd_ready, res_valid, busy;

    logic [2:0] a3, b3, ina3, inb3, r3_in, rnd3;
    logic ov3, or3, rv3, rr3, res3, busy3;

    msk_hpc2_feeder #(.d(2)) dut (
        .clk(clk), .rst(rst), .a_shares(a_sh), .b_shares(b_sh), .op_valid(op_valid),
        .op_ready(op_ready), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .ina(ina), .inb(inb), .rnd(rnd), .res_valid(res_valid), .busy(busy)
    );
    msk_hpc2_feeder #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .a_shares(a3), .b_shares(b3), .op_valid(ov3),
        .op_ready(or3), .rnd_in(r3_in), .rnd_valid(rv3), .rnd_ready(rr3),
        .ina(ina3), .inb(inb3), .rnd(rnd3), .res_valid(res3), .busy(busy3)
    );

    int compared = 0, mismatched = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {logic [1:0] a; logic [1:0] b;} pair_t;
    pair_t q[$];
    logic [1:0] a_pend;
    logic a_pend_v = 0, iss;
    logic [1:0] vp = 0;
    int n_issue = 0, n_res = 0, run = 0, last_run = 0;

    always @(negedge clk) begin
        iss = !rst && q.size() > 0 && rnd_valid;
        chk("op_ready", 32'(op_ready), 32'(rst || q.size() < 2));
        chk("rnd_ready", 32'(rnd_ready), 32'(iss));
        chk("inb", 32'(inb), iss ? 32'(q[0].b) : 32'd0);
        chk("rnd", 32'(rnd), iss ? 32'(rnd_in) : 32'd0);
        chk("ina", 32'(ina), (!rst && a_pend_v) ? 32'(a_pend) : 32'd0);
        chk("res_valid", 32'(res_valid), 32'(!rst && vp[1]));
        chk("busy", 32'(busy), 32'(!rst && (q.size() > 0 || vp != 2'b00)));
        if (rnd_ready) n_issue++;
        if (res_valid) begin
            n_res++;
            run++;
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (rst) begin
            q.delete();
            a_pend_v = 0;
            vp = 0;
        end else begin
            a_pend_v = iss;
            if (iss) a_pend = q.pop_front().a;
            vp = {vp[0], iss};
            if (op_valid && op_ready) q.push_back('{a: a_sh, b: b_sh});
        end
    end

    // Reference HPC2 AND gadget, fed from the d=3 feeder outputs.
    function automatic logic [2:0] hpc2(input logic [2:0] a, input logic [2:0] b, input logic [2:0] r);
        logic [2:0] c;
        for (int i = 0; i < 3; i++) begin
            c[i] = a[i] & b[i];
            for (int j = 0; j < 3; j++)
                if (j != i) begin
                    logic rij;
                    rij = r[(i < j ? i : j) + (i < j ? j : i) - 1];
                    c[i] = c[i] ^ (~a[i] & rij) ^ (a[i] & (b[j] ^ rij));
                end
        end
        return c;
    endfunction

    logic q3[$];
    logic g1_v = 0, g2_v = 0;
    logic [2:0] g1_b, g1_r, g2_c;
    int n_acc3 = 0, n_res3 = 0;

    always @(negedge clk) begin
        chk("res_valid3", 32'(res3), 32'(g2_v && !rst));
        if (res3) begin
            n_res3++;
            if (q3.size() == 0) chk("gadget_underflow", 32'd1, 32'd0);
            else chk("gadget_and", 32'(^g2_c), 32'(q3.pop_front()));
        end
        if (rst) begin
            q3.delete();
            g1_v = 0;
            g2_v = 0;
        end else begin
            if (!g1_v) chk("ina3_idle", 32'(ina3), 32'd0);
            g2_v = g1_v;
            if (g1_v) g2_c = hpc2(ina3, g1_b, g1_r);
            g1_v = rr3;
            g1_b = inb3;
            g1_r = rnd3;
            if (ov3 && or3) begin
                q3.push_back((^a3) & (^b3));
                n_acc3++;
            end
        end
    end

    task automatic step(input logic rs, input logic ov, input logic [1:0] a, input logic [1:0] b,
                        input logic rv, input logic r);
        @(posedge clk);
        #1;
        rst = rs; op_valid = ov; a_sh = a; b_sh = b; rnd_valid = rv; rnd_in = r;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 2'b00, 2'b00, 0, 0);
    endtask

    initial begin
        op_valid = 0; a_sh = 0; b_sh = 0; rnd_valid = 0; rnd_in = 0;
        ov3 = 0; a3 = 0; b3 = 0; rv3 = 0; r3_in = 0;
        step(1, 0, 2'b00, 2'b00, 0, 0);
        step(1, 1, 2'b11, 2'b11, 1, 1);
        // single op: inb/rnd at cycle 1, ina at 2, res_valid at 3
        step(0, 1, 2'b01, 2'b11, 1, 1);
        step(0, 0, 2'b00, 2'b00, 1, 1);
        #1 chk("inb_first", 32'(inb), 32'h3);
        chk("rnd_first", 32'(rnd), 32'h1);
        step(0, 0, 2'b00, 2'b00, 0, 0);
        #1 chk("ina_first", 32'(ina), 32'h1);
        step(0, 0, 2'b00, 2'b00, 0, 0);
        #1 chk("res_first", 32'(res_valid), 32'h1);
        idle(2);
        chk("run_single", 32'(last_run), 32'd1);
        // randomness stall: two ops buffered, third waits, then drains in order
        step(0, 1, 2'b01, 2'b10, 0, 0);
        step(0, 1, 2'b10, 2'b01, 0, 0);
        step(0, 1, 2'b11, 2'b00, 0, 0);
        #1 chk("full_ready", 32'(op_ready), 32'd0);
        step(0, 1, 2'b11, 2'b00, 0, 0);
        step(0, 1, 2'b11, 2'b00, 0, 0);
        step(0, 1, 2'b11, 2'b00, 1, 1);
        #1 chk("stall_inb1", 32'(inb), 32'h2);
        step(0, 1, 2'b11, 2'b00, 1, 0);
        #1 chk("stall_inb2", 32'(inb), 32'h1);
        step(0, 0, 2'b00, 2'b00, 1, 1);
        #1 chk("stall_inb3", 32'(inb), 32'h0);
        chk("stall_rnd3", 32'(rnd), 32'h1);
        idle(5);
        chk("run_stall", 32'(last_run), 32'd3);
        // streaming: one issue per cycle for ten cycles
        for (int i = 0; i < 10; i++) step(0, 1, 2'(i), ~2'(i), 1, i[0]);
        step(0, 0, 2'b00, 2'b00, 1, 0);
        idle(5);
        chk("run_stream", 32'(last_run), 32'd10);
        // reset one cycle after an issue aborts the in-flight op
        step(0, 1, 2'b10, 2'b11, 0, 0);
        step(0, 0, 2'b00, 2'b00, 1, 1);
        step(1, 0, 2'b00, 2'b00, 0, 0);
        #1 chk("rst_busy", 32'(busy), 32'd0);
        step(0, 0, 2'b00, 2'b00, 0, 0);
        #1 chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ina", 32'(ina), 32'd0);
        idle(3);
        // reset wins over a push and issue on a full FIFO
        step(0, 1, 2'b01, 2'b01, 0, 0);
        step(0, 1, 2'b10, 2'b10, 0, 0);
        step(1, 1, 2'b11, 2'b11, 1, 1);
        step(0, 0, 2'b00, 2'b00, 1, 1);
        #1 chk("rst_prio_rr", 32'(rnd_ready), 32'd0);
        idle(3);
        // d=3 random traffic checked through the gadget model
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            ov3 = $urandom_range(0, 3) != 0;
            rv3 = $urandom_range(0, 3) != 0;
            a3 = 3'($urandom);
            b3 = 3'($urandom);
            r3_in = 3'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            ov3 = 0;
            rv3 = 1;
            r3_in = 3'($urandom);
        end
        @(posedge clk);
        #1 rv3 = 0;
        idle(4);
        chk("total_issues", 32'(n_issue), 32'd15);
        chk("total_results", 32'(n_res), 32'd14);
        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("sb3_empty", 32'(q3.size()), 32'd0);
        chk("d3_results", 32'(n_res3), 32'(n_acc3));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
